mux2: RTL and testbench



---
 rtl/mux2_pkg.sv | 10 +
 rtl/mux2.sv | 57 +++++
 tb/tb_mux2.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mux2_pkg.sv
// mux2_pkg
// Project-wide parameters shared by the decode datapath blocks.
// Holds the default datapath word width that parameterised blocks
// such as mux2 use unless a caller overrides it.
package mux2_pkg;

  // Default datapath word width in bits.
  localparam int DEFAULT_WIDTH = 32;

endpackage : mux2_pkg

// File: rtl/mux2.sv
// mux2
// Parameterised 2:1 word multiplexer for the decode datapath.
// The output c carries operand b when cond is high, otherwise operand a.
// The select applies bit-for-bit over the whole word, with no extension.
//
// Parameters
//   WIDTH        data width of a, b and c (>= 1), defaults to DEFAULT_WIDTH
//   REGISTER_OUT 0 = combinational output, 1 = registered output with
//                one cycle of latency
//
// Ports
//   clk    in   1      rising-edge clock, used only when REGISTER_OUT = 1
//   reset  in   1      synchronous active-high reset, used only when
//                      REGISTER_OUT = 1; clears c at the next edge
//   a      in   WIDTH  operand selected when cond = 0
//   b      in   WIDTH  operand selected when cond = 1
//   cond   in   1      select control (a wider source connects only its LSB)
//   c      out  WIDTH  selected operand
module mux2
  import mux2_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter bit REGISTER_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cond,
  output logic [WIDTH-1:0] c
);

  generate
    if (REGISTER_OUT) begin : gen_reg
      // Pipelined variant: the selection is captured at each rising edge.
      // Reset only takes effect at an edge and drops whatever was in flight.
      always_ff @(posedge clk) begin
        if (reset) begin
          c <= '0;
        end else begin
          c <= cond ? b : a;
        end
      end
    end else begin : gen_comb
      // Purely combinational variant. The ?: form keeps the simulation
      // behaviour for an unknown cond: only bits where a and b agree
      // come out known.
      assign c = cond ? b : a;

      // Clock and reset have no function in this variant; they are
      // folded into a deliberately unused net so the ports stay uniform.
      logic unusedClkReset;
      assign unusedClkReset = clk ^ reset;
    end
  endgenerate

endmodule : mux2

// File: tb/tb_mux2.sv
// tb_mux2
// Self-checking bench for mux2. Three builds are instantiated:
//   dutComb  WIDTH = 32, combinational
//   dutReg   WIDTH = 32, registered
//   dutOne   WIDTH = 1,  combinational
// Inputs are driven shortly after a rising edge. Combinational outputs
// are checked at the falling edge, and the registered output is checked
// just after the following rising edge.
module tb_mux2;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] condSrc;
  logic [31:0] cComb;
  logic [31:0] cReg;

  logic        a1;
  logic        b1;
  logic        cond1;
  logic        c1;

  int          compared;
  int          mismatched;

  // Reference state for the registered build: the value it should be
  // holding after the most recent edge, and whether that is known yet.
  logic [31:0] regExp;
  bit          regKnown;

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The wide select source feeds only its LSB into cond.
  mux2 #(.WIDTH(32), .REGISTER_OUT(1'b0)) dutComb (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .cond  (condSrc[0]),
    .c     (cComb)
  );

  mux2 #(.WIDTH(32), .REGISTER_OUT(1'b1)) dutReg (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .cond  (condSrc[0]),
    .c     (cReg)
  );

  mux2 #(.WIDTH(1), .REGISTER_OUT(1'b0)) dutOne (
    .clk   (clk),
    .reset (reset),
    .a     (a1),
    .b     (b1),
    .cond  (cond1),
    .c     (c1)
  );

  // Reference select: an odd select source picks b, an even one picks a.
  function automatic logic [31:0] refSelect(input logic [31:0] opA,
                                            input logic [31:0] opB,
                                            input logic [31:0] src);
    return ((src % 2) == 1) ? opB : opA;
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drives one set of inputs just after a rising edge, checks the
  // combinational result and the registered hold value at the falling
  // edge, then checks the registered result just after the next edge.
  task automatic applyStimulus(input string tag, input logic [31:0] opA,
                               input logic [31:0] opB,
                               input logic [31:0] src, input logic rst);
    logic [31:0] combExp;
    a       = opA;
    b       = opB;
    condSrc = src;
    reset   = rst;
    combExp = refSelect(opA, opB, src);
    @(negedge clk);
    checkOutput({tag, "/comb"}, cComb, combExp);
    if (regKnown) checkOutput({tag, "/hold"}, cReg, regExp);
    regExp = rst ? 32'h0 : combExp;
    @(posedge clk);
    #1;
    checkOutput({tag, "/reg"}, cReg, regExp);
    regKnown = 1'b1;
  endtask

  // Watchdog so the run always ends even if something stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    regKnown   = 1'b0;
    regExp     = '0;
    reset      = 1'b1;
    a          = $urandom;
    b          = $urandom;
    condSrc    = $urandom;
    a1         = 1'b0;
    b1         = 1'b0;
    cond1      = 1'b0;

    @(posedge clk);
    #1;

    // Reset held across two edges clears the registered output.
    applyStimulus("rst0", $urandom, $urandom, $urandom, 1'b1);
    applyStimulus("rst1", $urandom, $urandom, $urandom, 1'b1);

    // Directed selections, including a full-width walk and an even wide
    // select source whose LSB alone decides.
    applyStimulus("selA",   32'h0000_0005, 32'h0000_000A, 32'h0, 1'b0);
    applyStimulus("selB",   32'h0000_000A - 32'h5 + 32'h0, 32'h0000_000A, 32'h1, 1'b0);
    applyStimulus("walkB",  32'hFFFF_FFFF, 32'h0000_0000, 32'h1, 1'b0);
    applyStimulus("walkA",  32'hFFFF_FFFF, 32'h0000_0000, 32'h0, 1'b0);
    applyStimulus("lsbOnly", 32'h0000_0001, 32'h0000_0002, 32'h0000_0002, 1'b0);

    // Pipelined sequence: load after release, then reset mid-stream.
    applyStimulus("pipe79",  32'd7, 32'd9, 32'h1, 1'b0);
    applyStimulus("pipeNxt", 32'd3, 32'd4, 32'h0, 1'b0);
    applyStimulus("midRst",  32'd3, 32'd4, 32'h1, 1'b1);
    applyStimulus("relLoad", 32'd7, 32'd9, 32'h1, 1'b0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 40; i++) begin
      applyStimulus("rand", $urandom, $urandom, $urandom,
                    ($urandom_range(0, 9) == 0));
    end

    // One-bit build: every (a, b, cond) combination.
    for (int i = 0; i < 8; i++) begin
      int expBit;
      a1    = ((i >> 2) % 2) == 1;
      b1    = ((i >> 1) % 2) == 1;
      cond1 = (i % 2) == 1;
      expBit = ((i % 2) == 1) ? ((i >> 1) % 2) : ((i >> 2) % 2);
      #2;
      checkOutput("w1", {31'h0, c1}, expBit[31:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule : tb_mux2
